// File: rtl/arbiter_pkg.sv
// Shared definitions for the weighted round-robin arbiter.
// Latency: none (types and helpers only).
// Backpressure: not applicable.
package arbiter_pkg;

  // Arbiter FSM: waiting for an eligible requester, or holding a grant.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // LSB position of a port's weight field within the packed weight bus.
  function automatic int weight_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Lowest-index-first priority encoder.
// Latency: combinational.
// Backpressure: not applicable.
module priority_encoder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         in_vec,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     found
);

  localparam int IW = $clog2(WIDTH);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_vec[i]) begin
        index = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter; optional grant watchdog under ARBITER_WRR_TIMEOUT_EN.
// Latency: grant registered 1 cycle after request; back-to-back grants on release.
// Backpressure: a grant is held until acknowledge or request drop of the granted port.
module arbiter_wrr #(
  parameter int PORTS        = 4,
  parameter int WEIGHT_WIDTH = 4
`ifdef ARBITER_WRR_TIMEOUT_EN
  , parameter int TIMEOUT    = 255
`endif
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PORTS-1:0]                request,
  input  logic [PORTS-1:0]                acknowledge,
  input  logic [PORTS*WEIGHT_WIDTH-1:0]   weight,
  output logic [PORTS-1:0]                grant,
  output logic                            grant_valid,
  output logic [$clog2(PORTS)-1:0]        grant_encoded
`ifdef ARBITER_WRR_TIMEOUT_EN
  , output logic                          timeout
`endif
);

  import arbiter_pkg::*;

  localparam int IW = $clog2(PORTS);
  localparam int WW = WEIGHT_WIDTH;

  state_t          state;
  logic [IW-1:0]   turn;
  logic [WW-1:0]   credit;

  logic [PORTS-1:0] eligible;
  logic [PORTS-1:0] above_turn;
  logic [IW-1:0]    hi_idx, all_idx, next_turn, arb_port;
  logic             hi_found, all_found;
  logic             keep_turn, release_now;
  logic [WW-1:0]    arb_credit;

`ifdef ARBITER_WRR_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] hold_cnt;
`endif

  // Zero-weight ports never compete; mask selects indices strictly after the turn.
  always_comb begin
    eligible   = '0;
    above_turn = '0;
    for (int i = 0; i < PORTS; i++) begin
      eligible[i]   = request[i] && (weight[weight_lsb(i, WW) +: WW] != '0);
      above_turn[i] = (i > int'(turn));
    end
  end

  priority_encoder #(.WIDTH(PORTS)) u_pe_above (
    .in_vec (eligible & above_turn),
    .index  (hi_idx),
    .found  (hi_found)
  );

  priority_encoder #(.WIDTH(PORTS)) u_pe_wrap (
    .in_vec (eligible),
    .index  (all_idx),
    .found  (all_found)
  );

  // Stay on the current turn while it has credit, otherwise rotate forward and reload.
  always_comb begin
    next_turn   = hi_found ? hi_idx : all_idx;
    keep_turn   = eligible[turn] && (credit != '0);
    arb_port    = keep_turn ? turn : next_turn;
    arb_credit  = keep_turn ? (credit - WW'(1))
                            : (weight[weight_lsb(int'(next_turn), WW) +: WW] - WW'(1));
    release_now = (state == ST_GRANT) &&
                  (acknowledge[grant_encoded] || !request[grant_encoded]);
  end

  // Arbiter FSM with registered grant outputs, turn and credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      turn          <= IW'(PORTS - 1);
      credit        <= '0;
`ifdef ARBITER_WRR_TIMEOUT_EN
      hold_cnt      <= '0;
      timeout       <= 1'b0;
`endif
    end else begin
`ifdef ARBITER_WRR_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (all_found) begin
            state         <= ST_GRANT;
            grant         <= PORTS'(1) << arb_port;
            grant_valid   <= 1'b1;
            grant_encoded <= arb_port;
            turn          <= arb_port;
            credit        <= arb_credit;
`ifdef ARBITER_WRR_TIMEOUT_EN
            hold_cnt      <= '0;
`endif
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            if (all_found) begin
              grant         <= PORTS'(1) << arb_port;
              grant_encoded <= arb_port;
              turn          <= arb_port;
              credit        <= arb_credit;
`ifdef ARBITER_WRR_TIMEOUT_EN
              hold_cnt      <= '0;
`endif
            end else begin
              state         <= ST_IDLE;
              grant         <= '0;
              grant_valid   <= 1'b0;
              grant_encoded <= '0;
            end
          end
`ifdef ARBITER_WRR_TIMEOUT_EN
          else if (hold_cnt == TW'(TIMEOUT - 1)) begin
            // Stuck grant: drop it and zero credit so the turn moves on.
            state         <= ST_IDLE;
            grant         <= '0;
            grant_valid   <= 1'b0;
            grant_encoded <= '0;
            credit        <= '0;
            timeout       <= 1'b1;
          end else begin
            hold_cnt      <= hold_cnt + TW'(1);
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/arbiter_wrr.md
Name: arbiter_wrr

Overview:
Weighted round-robin arbiter that shares one downstream resource (a mux output port, DMA engine or MAC TX path) between PORTS requesters. Each port holds the turn for up to weight[i] consecutive grants before the turn rotates, so bandwidth is split in proportion to the configured weights. A grant is held until the granted port acknowledges it. The interface matches the existing arbiter: request/acknowledge in, grant/grant_valid/grant_encoded out.

Parameters:
PORTS, 4, number of requesters (2..32)
WEIGHT_WIDTH, 4, bits per port weight; a port gets 1..2^WEIGHT_WIDTH-1 grants per turn

Ports:
clk  input  1  clock; all logic is on the rising edge
rst_n  input  1  asynchronous active-low reset
request  input  PORTS  per-port request level
acknowledge  input  PORTS  per-port release of a held grant
weight  input  PORTS*WEIGHT_WIDTH  port i weight at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; quasi-static
grant  output  PORTS  one-hot grant, registered
grant_valid  output  1  high when grant is nonzero
grant_encoded  output  $clog2(PORTS)  index of the granted port; 0 when no grant

Behaviour:
- Reset (rst_n low, asynchronous, takes effect mid-transaction): grant=0, grant_valid=0, grant_encoded=0, state=IDLE, turn=PORTS-1, credit=0. The first arbitration after reset rotates to the lowest eligible index.
- Eligible vector: request[i] & (weight[i]!=0). A port with zero weight is never granted.
- State IDLE: on a clock edge where the eligible vector is nonzero, arbitrate and go to GRANT. Grant appears 1 cycle after request is sampled.
- Arbitration:
  (a) If eligible[turn] and credit>0: grant turn, credit -= 1.
  (b) Otherwise: turn = first eligible index strictly after turn, wrapping PORTS-1 -> 0 (turn itself is checked last). Then credit = weight[turn]-1, and grant turn.
- State GRANT: grant is held stable. It is released on the edge where acknowledge[grant_encoded]=1 or request[grant_encoded]=0. Acknowledge bits of non-granted ports are ignored.
- On the release edge, arbitration runs in the same cycle against the current eligible vector. A nonzero result gives a back-to-back grant and the block stays in GRANT. A zero result clears grant and the block returns to IDLE.
- The same port can be re-granted back-to-back while credit remains.
- The weight input is sampled only when credit is reloaded (case b). Changing the weight mid-turn does not alter the current credit.
- Credit is WEIGHT_WIDTH bits wide and never underflows, because case (a) requires credit>0.
- Simultaneous release and a new request on a lower index: a rotation moves forward from turn and never goes back to a lower index.

Optional Feature:
ARBITER_WRR_TIMEOUT_EN
- Defined:
  - Adds parameter TIMEOUT (default 255) and output timeout (1 bit).
  - A counter runs while in GRANT and clears on every new grant.
  - When it reaches TIMEOUT without a release, the grant is forced off and timeout pulses high for 1 cycle.
  - The timed-out port's credit is zeroed, so the turn rotates.
  - Arbitration resumes from IDLE on the next cycle.
- Undefined: no counter, no extra port or parameter; the grant is held indefinitely.

Decomposition:
- Shared package arbiter_pkg: state encoding constants (ST_IDLE, ST_GRANT) and the helper for the weight-slice index.
- The rotation search uses the existing priority_encoder, instantiated twice:
  - once on eligible masked to indices > turn;
  - once on the unmasked eligible vector, used when the masked result is empty.
- No other sub-module.

Test Plan (PORTS=4, WEIGHT_WIDTH=4):
- Reset, then request=4'b0001, ack pulsed every grant -> grant=0001 one cycle after request, grant_encoded=0, grant_valid=1. During reset all outputs=0.
- weight={1,1,2,3} (port3..0), request=1111, ack each grant immediately -> grant_encoded sequence 0,0,0,1,1,2,3, then repeats.
- request=1111, ack withheld 5 cycles -> grant stable for 5 cycles. It releases on the ack edge and the next port is granted with no idle cycle.
- weight[2]=0, request=0100 -> grant_valid stays 0. Then request=0110 -> port 1 is granted and port 2 is never granted.
- Port 1 granted with credit 2, rst_n pulsed low mid-grant -> outputs clear immediately (asynchronously). After release, request=0010 -> grant=0010 again with a fresh credit reload.
- With ARBITER_WRR_TIMEOUT_EN, TIMEOUT=8, grant port 0 and never ack -> grant drops after 8 cycles, timeout pulses once. With request=0011 the next grant goes to port 1.
